// File: rtl/dm_port_arbiter.sv
// ============================================================================
// dm_port_arbiter
// ----------------------------------------------------------------------------
// Purpose:
//   Two-port round-robin arbiter and access sequencer for the 4 KB data
//   memory (dm_4k). Port 0 is the CPU load/store unit and port 1 is the
//   DMA/debug loader. A granted request moves through a three-stage pipeline:
//   ARB (grant) -> ACC (memory access) -> RSP (response pulse). One access is
//   issued per cycle with no stalls, and responses return in grant order.
//
// Ports:
//   clk, rst_n               rising-edge clock, asynchronous active-low reset
//   pN_req                   request from port N, held until granted
//   pN_we / pN_byte / pN_uns store, byte access, zero-extended byte load
//   pN_addr / pN_wdata       byte address, store data (byte stores use [7:0])
//   pN_gnt                   combinational accept strobe for this clock edge
//   pN_rvalid                one-cycle response pulse for loads and stores
//   pN_rdata                 load data, zero whenever pN_rvalid is low
//   pN_err                   misaligned word access, qualified by pN_rvalid
//   dm_sb/dm_lb/dm_lbu       memory access-type controls
//   dm_addr / dm_din / dm_wr memory address, write data, write enable
//   dm_dout                  memory read data, combinational from dm_addr
//
// Configuration:
//   DM_ARB_ALIGN_CHECK_EN  when defined, word accesses with addr[1:0] != 0
//                          are flagged: no write, load data 0, pN_err set.
//                          When undefined, word accesses have dm_addr[1:0]
//                          forced to 00 and pN_err is always 0.
// ============================================================================
module dm_port_arbiter #(
    parameter int AW = 12,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic          p0_req,
    input  logic          p0_we,
    input  logic          p0_byte,
    input  logic          p0_uns,
    input  logic [AW-1:0] p0_addr,
    input  logic [DW-1:0] p0_wdata,
    output logic          p0_gnt,
    output logic          p0_rvalid,
    output logic [DW-1:0] p0_rdata,
    output logic          p0_err,

    input  logic          p1_req,
    input  logic          p1_we,
    input  logic          p1_byte,
    input  logic          p1_uns,
    input  logic [AW-1:0] p1_addr,
    input  logic [DW-1:0] p1_wdata,
    output logic          p1_gnt,
    output logic          p1_rvalid,
    output logic [DW-1:0] p1_rdata,
    output logic          p1_err,

    output logic          dm_sb,
    output logic          dm_lb,
    output logic          dm_lbu,
    output logic [AW-1:0] dm_addr,
    output logic [DW-1:0] dm_din,
    output logic          dm_wr,
    input  logic [DW-1:0] dm_dout
);

    // Last-grant pointer: 1 means port 1 was granted most recently.
    logic          last_q, last_d;

    // ACC stage register
    logic          acc_valid_q, acc_valid_d;
    logic          acc_port_q,  acc_port_d;
    logic          acc_we_q,    acc_we_d;
    logic          acc_byte_q,  acc_byte_d;
    logic          acc_uns_q,   acc_uns_d;
    logic [AW-1:0] acc_addr_q,  acc_addr_d;
    logic [DW-1:0] acc_wdata_q, acc_wdata_d;

    // RSP stage register
    logic          rsp_valid_q, rsp_valid_d;
    logic          rsp_port_q,  rsp_port_d;
    logic          rsp_err_q,   rsp_err_d;
    logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;

    logic          acc_mis;
    logic          gnt0, gnt1;

    // ------------------------------------------------------------------------
    // ARB stage. On a conflict the port that was not granted last wins.
    // Grants are gated by rst_n so nothing is accepted while held in reset.
    // ------------------------------------------------------------------------
    always_comb begin
        gnt0   = rst_n & p0_req & (~p1_req | last_q);
        gnt1   = rst_n & p1_req & (~p0_req | ~last_q);
        last_d = last_q;
        if (gnt0) begin
            last_d = 1'b0;
        end else if (gnt1) begin
            last_d = 1'b1;
        end
    end

    assign p0_gnt = gnt0;
    assign p1_gnt = gnt1;

    // Capture the winning request; payload fields hold when idle so that
    // dm_addr and dm_din keep their last values.
    always_comb begin
        acc_valid_d = gnt0 | gnt1;
        acc_port_d  = acc_port_q;
        acc_we_d    = acc_we_q;
        acc_byte_d  = acc_byte_q;
        acc_uns_d   = acc_uns_q;
        acc_addr_d  = acc_addr_q;
        acc_wdata_d = acc_wdata_q;
        if (gnt0) begin
            acc_port_d  = 1'b0;
            acc_we_d    = p0_we;
            acc_byte_d  = p0_byte;
            acc_uns_d   = p0_uns;
            acc_addr_d  = p0_addr;
            acc_wdata_d = p0_wdata;
        end else if (gnt1) begin
            acc_port_d  = 1'b1;
            acc_we_d    = p1_we;
            acc_byte_d  = p1_byte;
            acc_uns_d   = p1_uns;
            acc_addr_d  = p1_addr;
            acc_wdata_d = p1_wdata;
        end
    end

    // ------------------------------------------------------------------------
    // ACC stage: drive the memory. Misaligned words are either flagged or
    // silently realigned depending on the build option.
    // ------------------------------------------------------------------------
`ifdef DM_ARB_ALIGN_CHECK_EN
    assign acc_mis = ~acc_byte_q & (acc_addr_q[1:0] != 2'b00);
    assign dm_addr = acc_addr_q;
`else
    assign acc_mis = 1'b0;
    assign dm_addr = acc_byte_q ? acc_addr_q : {acc_addr_q[AW-1:2], 2'b00};
`endif

    assign dm_din = acc_wdata_q;
    assign dm_wr  = acc_valid_q & acc_we_q & ~acc_mis;
    assign dm_sb  = acc_valid_q & acc_byte_q & acc_we_q;
    assign dm_lb  = acc_valid_q & acc_byte_q & ~acc_we_q & ~acc_uns_q;
    assign dm_lbu = acc_valid_q & acc_byte_q & ~acc_we_q & acc_uns_q;

    // Read data is sampled at the same edge that commits a write, so a load
    // in the following ACC cycle always observes the new contents.
    always_comb begin
        rsp_valid_d = acc_valid_q;
        rsp_port_d  = acc_valid_q ? acc_port_q : rsp_port_q;
        rsp_err_d   = acc_valid_q & acc_mis;
        rsp_rdata_d = '0;
        if (acc_valid_q & ~acc_we_q & ~acc_mis) begin
            rsp_rdata_d = dm_dout;
        end
    end

    // ------------------------------------------------------------------------
    // RSP stage: steer the response pulse to the captured port only.
    // ------------------------------------------------------------------------
    assign p0_rvalid = rsp_valid_q & ~rsp_port_q;
    assign p1_rvalid = rsp_valid_q & rsp_port_q;
    assign p0_rdata  = p0_rvalid ? rsp_rdata_q : '0;
    assign p1_rdata  = p1_rvalid ? rsp_rdata_q : '0;
    assign p0_err    = p0_rvalid & rsp_err_q;
    assign p1_err    = p1_rvalid & rsp_err_q;

    // ------------------------------------------------------------------------
    // State registers. Reset discards any access in flight.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q      <= 1'b1;
            acc_valid_q <= 1'b0;
            acc_port_q  <= 1'b0;
            acc_we_q    <= 1'b0;
            acc_byte_q  <= 1'b0;
            acc_uns_q   <= 1'b0;
            acc_addr_q  <= '0;
            acc_wdata_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_port_q  <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            last_q      <= last_d;
            acc_valid_q <= acc_valid_d;
            acc_port_q  <= acc_port_d;
            acc_we_q    <= acc_we_d;
            acc_byte_q  <= acc_byte_d;
            acc_uns_q   <= acc_uns_d;
            acc_addr_q  <= acc_addr_d;
            acc_wdata_q <= acc_wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_port_q  <= rsp_port_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

endmodule

// File: tb/tb_dm_port_arbiter.sv
// ============================================================================
// tb_dm_port_arbiter
// ----------------------------------------------------------------------------
// Directed testbench for dm_port_arbiter. A small dm_4k model (little-endian,
// word array, combinational read with lb/lbu extension, byte or word write on
// the rising edge) sits behind the memory port. Inputs change on the falling
// edge and outputs are sampled 1 ns later.
// ============================================================================
module tb_dm_port_arbiter;

    localparam int AW = 12;
    localparam int DW = 32;

`ifdef DM_ARB_ALIGN_CHECK_EN
    localparam logic MIS_EN = 1'b1;
`else
    localparam logic MIS_EN = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    logic          p0_req, p0_we, p0_byte, p0_uns;
    logic [AW-1:0] p0_addr;
    logic [DW-1:0] p0_wdata;
    logic          p0_gnt, p0_rvalid, p0_err;
    logic [DW-1:0] p0_rdata;
    logic          p1_req, p1_we, p1_byte, p1_uns;
    logic [AW-1:0] p1_addr;
    logic [DW-1:0] p1_wdata;
    logic          p1_gnt, p1_rvalid, p1_err;
    logic [DW-1:0] p1_rdata;
    logic          dm_sb, dm_lb, dm_lbu, dm_wr;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_din;
    logic [DW-1:0] dm_dout;

    int checks;
    int failures;

    dm_port_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .p0_req    (p0_req),
        .p0_we     (p0_we),
        .p0_byte   (p0_byte),
        .p0_uns    (p0_uns),
        .p0_addr   (p0_addr),
        .p0_wdata  (p0_wdata),
        .p0_gnt    (p0_gnt),
        .p0_rvalid (p0_rvalid),
        .p0_rdata  (p0_rdata),
        .p0_err    (p0_err),
        .p1_req    (p1_req),
        .p1_we     (p1_we),
        .p1_byte   (p1_byte),
        .p1_uns    (p1_uns),
        .p1_addr   (p1_addr),
        .p1_wdata  (p1_wdata),
        .p1_gnt    (p1_gnt),
        .p1_rvalid (p1_rvalid),
        .p1_rdata  (p1_rdata),
        .p1_err    (p1_err),
        .dm_sb     (dm_sb),
        .dm_lb     (dm_lb),
        .dm_lbu    (dm_lbu),
        .dm_addr   (dm_addr),
        .dm_din    (dm_din),
        .dm_wr     (dm_wr),
        .dm_dout   (dm_dout)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // dm_4k model
    logic [31:0] mem [0:1023];
    logic [31:0] mem_word;
    logic [7:0]  mem_byte;

    assign mem_word = mem[dm_addr[11:2]];
    assign mem_byte = mem_word[{dm_addr[1:0], 3'b000} +: 8];

    always_comb begin
        dm_dout = mem_word;
        if (dm_lb) begin
            dm_dout = {{24{mem_byte[7]}}, mem_byte};
        end else if (dm_lbu) begin
            dm_dout = {24'h0, mem_byte};
        end
    end

    always @(posedge clk) begin
        if (dm_wr) begin
            if (dm_sb) begin
                mem[dm_addr[11:2]][{dm_addr[1:0], 3'b000} +: 8] <= dm_din[7:0];
            end else begin
                mem[dm_addr[11:2]] <= dm_din;
            end
        end
    end

    // Stimulus helpers (drive only)
    task automatic set_p0(input logic req, input logic we, input logic bt,
                          input logic uns, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata);
        p0_req = req; p0_we = we; p0_byte = bt; p0_uns = uns;
        p0_addr = addr; p0_wdata = wdata;
    endtask

    task automatic set_p1(input logic req, input logic we, input logic bt,
                          input logic uns, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata);
        p1_req = req; p1_we = we; p1_byte = bt; p1_uns = uns;
        p1_addr = addr; p1_wdata = wdata;
    endtask

    task automatic do_reset;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ------------------------------------------------------------------------
    // Reset state: every output is zero while held in reset and just after.
    // ------------------------------------------------------------------------
    task automatic test_reset;
        @(negedge clk); #1;
        checks++; if ({p0_gnt, p1_gnt} !== 2'b00) begin failures++; $display("[TB] FAIL rst_gnt: got %b want 00", {p0_gnt, p1_gnt}); end
        checks++; if ({p0_rvalid, p1_rvalid, p0_err, p1_err} !== 4'b0000) begin failures++; $display("[TB] FAIL rst_rsp: got %b want 0000", {p0_rvalid, p1_rvalid, p0_err, p1_err}); end
        checks++; if ((p0_rdata | p1_rdata) !== 32'h0) begin failures++; $display("[TB] FAIL rst_rdata: got %h want 0", p0_rdata | p1_rdata); end
        checks++; if ({dm_wr, dm_sb, dm_lb, dm_lbu} !== 4'b0000) begin failures++; $display("[TB] FAIL rst_dmctl: got %b want 0000", {dm_wr, dm_sb, dm_lb, dm_lbu}); end
        checks++; if (dm_addr !== 12'h0) begin failures++; $display("[TB] FAIL rst_dm_addr: got %h want 000", dm_addr); end
        checks++; if (dm_din !== 32'h0) begin failures++; $display("[TB] FAIL rst_dm_din: got %h want 0", dm_din); end
        rst_n = 1'b1;
        @(negedge clk); #1;
        checks++; if ({p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, dm_wr} !== 5'b0) begin failures++; $display("[TB] FAIL rst_idle: got %b want 00000", {p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, dm_wr}); end
    endtask

    // ------------------------------------------------------------------------
    // Word store 4 @0 then word load @0 on the next cycle.
    // ------------------------------------------------------------------------
    task automatic test_word_access;
        @(negedge clk); set_p0(1, 1, 0, 0, 12'h000, 32'h4); #1;
        checks++; if ({p0_gnt, p1_gnt} !== 2'b10) begin failures++; $display("[TB] FAIL ws_gnt: got %b want 10", {p0_gnt, p1_gnt}); end
        @(negedge clk); set_p0(1, 0, 0, 0, 12'h000, 32'h0); #1;
        checks++; if (p0_gnt !== 1'b1) begin failures++; $display("[TB] FAIL wl_gnt: got %b want 1", p0_gnt); end
        checks++; if ({dm_wr, dm_sb} !== 2'b10) begin failures++; $display("[TB] FAIL ws_acc_ctl: got %b want 10", {dm_wr, dm_sb}); end
        checks++; if (dm_din !== 32'h4) begin failures++; $display("[TB] FAIL ws_acc_din: got %h want 00000004", dm_din); end
        checks++; if (dm_addr !== 12'h000) begin failures++; $display("[TB] FAIL ws_acc_addr: got %h want 000", dm_addr); end
        @(negedge clk); set_p0(0, 0, 0, 0, 12'h000, 32'h0); #1;
        checks++; if ({p0_rvalid, p1_rvalid} !== 2'b10) begin failures++; $display("[TB] FAIL ws_rvalid: got %b want 10", {p0_rvalid, p1_rvalid}); end
        checks++; if (p0_rdata !== 32'h0) begin failures++; $display("[TB] FAIL ws_rdata: got %h want 0", p0_rdata); end
        checks++; if ({dm_wr, dm_lb, dm_lbu} !== 3'b000) begin failures++; $display("[TB] FAIL wl_acc_ctl: got %b want 000", {dm_wr, dm_lb, dm_lbu}); end
        @(negedge clk); #1;
        checks++; if (p0_rvalid !== 1'b1) begin failures++; $display("[TB] FAIL wl_rvalid: got %b want 1", p0_rvalid); end
        checks++; if (p0_rdata !== 32'h4) begin failures++; $display("[TB] FAIL wl_rdata: got %h want 00000004", p0_rdata); end
        checks++; if (p0_err !== 1'b0) begin failures++; $display("[TB] FAIL wl_err: got %b want 0", p0_err); end
        @(negedge clk); #1;
        checks++; if ({p0_rvalid, dm_wr} !== 2'b00) begin failures++; $display("[TB] FAIL w_quiet: got %b want 00", {p0_rvalid, dm_wr}); end
    endtask

    // ------------------------------------------------------------------------
    // Byte store 0x00301046 @0 then lb @0: only the low byte lands.
    // ------------------------------------------------------------------------
    task automatic test_byte_access;
        @(negedge clk); set_p0(1, 1, 1, 0, 12'h000, 32'h00301046); #1;
        checks++; if (p0_gnt !== 1'b1) begin failures++; $display("[TB] FAIL bs_gnt: got %b want 1", p0_gnt); end
        @(negedge clk); set_p0(1, 0, 1, 0, 12'h000, 32'h0); #1;
        checks++; if ({dm_wr, dm_sb, dm_lb, dm_lbu} !== 4'b1100) begin failures++; $display("[TB] FAIL bs_acc_ctl: got %b want 1100", {dm_wr, dm_sb, dm_lb, dm_lbu}); end
        @(negedge clk); set_p0(0, 0, 0, 0, 12'h000, 32'h0); #1;
        checks++; if ({dm_wr, dm_sb, dm_lb, dm_lbu} !== 4'b0010) begin failures++; $display("[TB] FAIL bl_acc_ctl: got %b want 0010", {dm_wr, dm_sb, dm_lb, dm_lbu}); end
        @(negedge clk); #1;
        checks++; if (p0_rdata !== 32'h00000046) begin failures++; $display("[TB] FAIL bl_rdata: got %h want 00000046", p0_rdata); end
    endtask

    // ------------------------------------------------------------------------
    // Byte 0xF0 at @2: lb sign-extends, lbu zero-extends.
    // ------------------------------------------------------------------------
    task automatic test_sign_extend;
        @(negedge clk); set_p0(1, 1, 1, 0, 12'h002, 32'h000000F0); #1;
        @(negedge clk); set_p0(1, 0, 1, 0, 12'h002, 32'h0); #1;
        checks++; if (dm_addr !== 12'h002) begin failures++; $display("[TB] FAIL sb2_addr: got %h want 002", dm_addr); end
        @(negedge clk); set_p0(1, 0, 1, 1, 12'h002, 32'h0); #1;
        checks++; if ({dm_lb, dm_lbu} !== 2'b10) begin failures++; $display("[TB] FAIL lb_acc_ctl: got %b want 10", {dm_lb, dm_lbu}); end
        @(negedge clk); set_p0(0, 0, 0, 0, 12'h000, 32'h0); #1;
        checks++; if (p0_rdata !== 32'hFFFFFFF0) begin failures++; $display("[TB] FAIL lb_rdata: got %h want FFFFFFF0", p0_rdata); end
        checks++; if ({dm_lb, dm_lbu} !== 2'b01) begin failures++; $display("[TB] FAIL lbu_acc_ctl: got %b want 01", {dm_lb, dm_lbu}); end
        @(negedge clk); #1;
        checks++; if (p0_rdata !== 32'h000000F0) begin failures++; $display("[TB] FAIL lbu_rdata: got %h want 000000F0", p0_rdata); end
    endtask

    // ------------------------------------------------------------------------
    // Port 1 word accesses at @4 and a misaligned word store at @6.
    // ------------------------------------------------------------------------
    task automatic test_misaligned;
        @(negedge clk); set_p1(1, 1, 0, 0, 12'h004, 32'hCAFEBABE); #1;
        checks++; if ({p0_gnt, p1_gnt} !== 2'b01) begin failures++; $display("[TB] FAIL ma_gnt: got %b want 01", {p0_gnt, p1_gnt}); end
        @(negedge clk); set_p1(1, 1, 0, 0, 12'h006, 32'h12345678); #1;
        @(negedge clk); set_p1(1, 0, 0, 0, 12'h004, 32'h0); #1;
        checks++; if ({p1_rvalid, p1_err} !== 2'b10) begin failures++; $display("[TB] FAIL ma_st1_rsp: got %b want 10", {p1_rvalid, p1_err}); end
        checks++; if (dm_wr !== ~MIS_EN) begin failures++; $display("[TB] FAIL ma_st2_wr: got %b want %b", dm_wr, ~MIS_EN); end
        checks++; if (dm_addr !== (MIS_EN ? 12'h006 : 12'h004)) begin failures++; $display("[TB] FAIL ma_st2_addr: got %h want %h", dm_addr, MIS_EN ? 12'h006 : 12'h004); end
        @(negedge clk); set_p1(0, 0, 0, 0, 12'h000, 32'h0); #1;
        checks++; if ({p1_rvalid, p1_err} !== {1'b1, MIS_EN}) begin failures++; $display("[TB] FAIL ma_st2_rsp: got %b want %b", {p1_rvalid, p1_err}, {1'b1, MIS_EN}); end
        @(negedge clk); #1;
        checks++; if (p1_rdata !== (MIS_EN ? 32'hCAFEBABE : 32'h12345678)) begin failures++; $display("[TB] FAIL ma_ld_rdata: got %h want %h", p1_rdata, MIS_EN ? 32'hCAFEBABE : 32'h12345678); end
        checks++; if (p1_err !== 1'b0) begin failures++; $display("[TB] FAIL ma_ld_err: got %b want 0", p1_err); end
    endtask

    // ------------------------------------------------------------------------
    // Both ports request for 6 cycles right after reset: grants alternate
    // starting with port 0, responses follow 2 cycles later on the same port.
    // ------------------------------------------------------------------------
    task automatic test_round_robin;
        logic [31:0] w1;
        logic        eg0, eg1, ev0, ev1;
        w1 = MIS_EN ? 32'hCAFEBABE : 32'h12345678;
        do_reset();
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            set_p0(k < 6, 0, 0, 0, 12'h000, 32'h0);
            set_p1(k < 6, 0, 0, 0, 12'h004, 32'h0);
            #1;
            eg0 = (k < 6) && (k % 2 == 0);
            eg1 = (k < 6) && (k % 2 == 1);
            ev0 = (k >= 2) && (k % 2 == 0);
            ev1 = (k >= 2) && (k % 2 == 1);
            checks++; if ({p0_gnt, p1_gnt} !== {eg0, eg1}) begin failures++; $display("[TB] FAIL rr_gnt[%0d]: got %b want %b", k, {p0_gnt, p1_gnt}, {eg0, eg1}); end
            checks++; if ({p0_rvalid, p1_rvalid} !== {ev0, ev1}) begin failures++; $display("[TB] FAIL rr_rvalid[%0d]: got %b want %b", k, {p0_rvalid, p1_rvalid}, {ev0, ev1}); end
            checks++; if (p0_rdata !== (ev0 ? 32'h00F00046 : 32'h0)) begin failures++; $display("[TB] FAIL rr_p0_rdata[%0d]: got %h want %h", k, p0_rdata, ev0 ? 32'h00F00046 : 32'h0); end
            checks++; if (p1_rdata !== (ev1 ? w1 : 32'h0)) begin failures++; $display("[TB] FAIL rr_p1_rdata[%0d]: got %h want %h", k, p1_rdata, ev1 ? w1 : 32'h0); end
        end
    endtask

    // ------------------------------------------------------------------------
    // Reset asserted during the ACC cycle of a store: no write, no response.
    // ------------------------------------------------------------------------
    task automatic test_reset_in_flight;
        @(negedge clk); set_p0(1, 1, 0, 0, 12'h008, 32'hDEADBEEF); #1;
        checks++; if (p0_gnt !== 1'b1) begin failures++; $display("[TB] FAIL rif_gnt: got %b want 1", p0_gnt); end
        @(negedge clk); set_p0(0, 0, 0, 0, 12'h000, 32'h0); rst_n = 1'b0; #1;
        checks++; if ({dm_wr, dm_sb, dm_lb, dm_lbu} !== 4'b0000) begin failures++; $display("[TB] FAIL rif_dmctl: got %b want 0000", {dm_wr, dm_sb, dm_lb, dm_lbu}); end
        checks++; if ({dm_addr, dm_din} !== 44'h0) begin failures++; $display("[TB] FAIL rif_dm_bus: got %h want 0", {dm_addr, dm_din}); end
        @(negedge clk); #1;
        checks++; if ({p0_rvalid, p1_rvalid, p0_gnt, p1_gnt} !== 4'b0000) begin failures++; $display("[TB] FAIL rif_rsp: got %b want 0000", {p0_rvalid, p1_rvalid, p0_gnt, p1_gnt}); end
        rst_n = 1'b1;
        @(negedge clk); set_p0(1, 0, 0, 0, 12'h008, 32'h0); #1;
        checks++; if (p0_rvalid !== 1'b0) begin failures++; $display("[TB] FAIL rif_no_rsp: got %b want 0", p0_rvalid); end
        @(negedge clk); set_p0(0, 0, 0, 0, 12'h000, 32'h0);
        @(negedge clk); #1;
        checks++; if ({p0_rvalid, p0_rdata} !== {1'b1, 32'h0}) begin failures++; $display("[TB] FAIL rif_mem: got %b/%h want 1/00000000", p0_rvalid, p0_rdata); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        rst_n = 1'b0;
        set_p0(0, 0, 0, 0, 12'h000, 32'h0);
        set_p1(0, 0, 0, 0, 12'h000, 32'h0);
        test_reset();
        test_word_access();
        test_byte_access();
        test_sign_extend();
        test_misaligned();
        test_round_robin();
        test_reset_in_flight();
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
